// File: rtl/sm_reg_scan_if.sv
// Register readout stream: one {address, value} pair per valid/ready handshake.
interface sm_reg_scan_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              outValid;
   logic              outReady;
   logic [ADDR_W-1:0] outAddr;
   logic [DATA_W-1:0] outData;

   modport master (output outValid, outAddr, outData, input outReady);
   modport slave  (input outValid, outAddr, outData, output outReady);
endinterface

// File: rtl/sm_reg_scan_ctrl.sv
// Debug-readout controller for schoolMIPS: halts the core, walks the register file
// through regAddr/regData and streams each {address, value} pair to a formatter.
module sm_reg_scan_ctrl #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int REG_FIRST = 1,
   parameter int REG_LAST  = 31,
   parameter int HALT_CYC  = 16,
   parameter int SETTLE    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              runEn,
   input  logic              scanReq,
   input  logic [DATA_W-1:0] regData,
   output logic [ADDR_W-1:0] regAddr,
   output logic              clkEnable,
   sm_reg_scan_if.master     outBus,
   output logic              busy,
   output logic              done
);

   localparam int CNT_MAX = (HALT_CYC > SETTLE) ? HALT_CYC : SETTLE;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]  HALT_LOAD   = CNT_W'(HALT_CYC - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR  = ADDR_W'(REG_FIRST);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(REG_LAST);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_SETTLE,
      ST_EMIT,
      ST_FINISH
   } state_t;

   state_t            state,      stateNxt;
   logic [CNT_W-1:0]  cnt,        cntNxt;
   logic [ADDR_W-1:0] regAddrQ,   regAddrNxt;
   logic              clkEnQ,     clkEnNxt;
   logic              validQ,     validNxt;
   logic [ADDR_W-1:0] outAddrQ,   outAddrNxt;
   logic [DATA_W-1:0] outDataQ,   outDataNxt;
   logic              busyQ,      busyNxt;
   logic              doneQ,      doneNxt;

   // NOTE: every state element uses <= so all registers update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         regAddrQ <= FIRST_ADDR;
         clkEnQ   <= 1'b0;
         validQ   <= 1'b0;
         outAddrQ <= '0;
         outDataQ <= '0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
      end else begin
         state    <= stateNxt;
         cnt      <= cntNxt;
         regAddrQ <= regAddrNxt;
         clkEnQ   <= clkEnNxt;
         validQ   <= validNxt;
         outAddrQ <= outAddrNxt;
         outDataQ <= outDataNxt;
         busyQ    <= busyNxt;
         doneQ    <= doneNxt;
      end
   end

   // NOTE: each signal gets a hold/default value first so no path through the case infers a latch.
   always_comb begin
      stateNxt   = state;
      cntNxt     = cnt;
      regAddrNxt = regAddrQ;
      clkEnNxt   = clkEnQ;
      validNxt   = validQ;
      outAddrNxt = outAddrQ;
      outDataNxt = outDataQ;
      busyNxt    = busyQ;
      doneNxt    = 1'b0;

      case (state)
         ST_IDLE: begin
            clkEnNxt = runEn;
            if (scanReq) begin
               clkEnNxt   = 1'b0;
               busyNxt    = 1'b1;
               cntNxt     = HALT_LOAD;
               regAddrNxt = FIRST_ADDR;
               stateNxt   = ST_HALT;
            end
         end
         ST_HALT: begin
            if (cnt == '0) begin
               cntNxt   = SETTLE_LOAD;
               stateNxt = ST_SETTLE;
            end else begin
               cntNxt = cnt - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            // regData has had SETTLE cycles to follow the new regAddr.
            if (cnt == '0) begin
               outDataNxt = regData;
               outAddrNxt = regAddrQ;
               validNxt   = 1'b1;
               stateNxt   = ST_EMIT;
            end else begin
               cntNxt = cnt - CNT_W'(1);
            end
         end
         ST_EMIT: begin
            if (validQ && outBus.outReady) begin
               validNxt = 1'b0;
               if (regAddrQ == LAST_ADDR) begin
                  stateNxt = ST_FINISH;
               end else begin
                  regAddrNxt = regAddrQ + ADDR_W'(1);
                  cntNxt     = SETTLE_LOAD;
                  stateNxt   = ST_SETTLE;
               end
            end
         end
         ST_FINISH: begin
            doneNxt  = 1'b1;
            busyNxt  = 1'b0;
            clkEnNxt = runEn;
            stateNxt = ST_IDLE;
         end
         default: stateNxt = ST_IDLE;
      endcase
   end

   assign regAddr         = regAddrQ;
   assign clkEnable       = clkEnQ;
   assign busy            = busyQ;
   assign done            = doneQ;
   assign outBus.outValid = validQ;
   assign outBus.outAddr  = outAddrQ;
   assign outBus.outData  = outDataQ;

endmodule

// File: tb/tb_sm_reg_scan_ctrl.sv
// Bench for sm_reg_scan_ctrl: queued expected pairs checked by a stream monitor,
// plus directed checks of halt timing, backpressure, ignored requests and reset.
module tb_sm_reg_scan_ctrl;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int HALT_CYC = 16;
   localparam int SETTLE   = 2;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } pair_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              runEn, scanReq, scanReq2;
   logic [DATA_W-1:0] regData, regData2;
   logic [ADDR_W-1:0] regAddr, regAddr2;
   logic              clkEnable, clkEnable2, busy, busy2, done, done2;

   sm_reg_scan_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) outIf ();
   sm_reg_scan_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) outIf2 ();

   sm_reg_scan_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_FIRST(1), .REG_LAST(31),
      .HALT_CYC(HALT_CYC), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .runEn(runEn), .scanReq(scanReq), .regData(regData),
      .regAddr(regAddr), .clkEnable(clkEnable), .outBus(outIf), .busy(busy), .done(done)
   );

   sm_reg_scan_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_FIRST(2), .REG_LAST(2),
      .HALT_CYC(HALT_CYC), .SETTLE(SETTLE)
   ) dut2 (
      .clk(clk), .rst(rst), .runEn(runEn), .scanReq(scanReq2), .regData(regData2),
      .regAddr(regAddr2), .clkEnable(clkEnable2), .outBus(outIf2), .busy(busy2), .done(done2)
   );

   function automatic logic [DATA_W-1:0] rfVal(input logic [ADDR_W-1:0] a);
      return 32'h9E37_79B9 * {27'd0, a} + 32'h0000_1357;
   endfunction

   // Register file model with one cycle of read latency, like a registered sm_top readout.
   always @(posedge clk) begin
      regData  <= rfVal(regAddr);
      regData2 <= rfVal(regAddr2);
   end

   int    nChecks = 0;
   int    nFails  = 0;
   int    pairsSeen = 0;
   int    pairs2 = 0;
   int    doneCnt = 0;
   int    doneCnt2 = 0;
   pair_t expQ[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream monitor: every accepted pair must be the next one the stimulus queued.
   always @(negedge clk) begin
      if (!rst && outIf.outValid && outIf.outReady) begin
         pairsSeen++;
         if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected pair: got addr %0d data %0h, none expected", outIf.outAddr, outIf.outData);
         end else begin
            pair_t e;
            e = expQ.pop_front();
            check("pair addr", 64'(outIf.outAddr), 64'(e.addr));
            check("pair data", 64'(outIf.outData), 64'(e.data));
         end
      end
      if (!rst && outIf2.outValid && outIf2.outReady) begin
         pairs2++;
         check("single pair", {27'd0, outIf2.outAddr, outIf2.outData}, {27'd0, 5'd2, rfVal(5'd2)});
      end
      if (done)  doneCnt++;
      if (done2) doneCnt2++;
   end

   task automatic pushRange(input int first, input int last);
      for (int a = first; a <= last; a++) begin
         pair_t p;
         p.addr = ADDR_W'(a);
         p.data = rfVal(ADDR_W'(a));
         expQ.push_back(p);
      end
   endtask

   // Called just after a rising edge; leaves time just after the edge that samples the pulse.
   task automatic pulseScan();
      scanReq = 1'b1;
      @(posedge clk); #1;
      scanReq = 1'b0;
   endtask

   task automatic waitDone(input string name, input int maxCyc);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < maxCyc; c++) begin
         @(posedge clk); #1;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 64'(ok), 64'd1);
   endtask

   task automatic waitRegAddr(input string name, input logic [ADDR_W-1:0] a);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (regAddr == a) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 64'(ok), 64'd1);
   endtask

   task automatic waitValid(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (outIf.outValid) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 64'(ok), 64'd1);
   endtask

   initial begin
      int lat, leak, doneBase, pairBase, busySeen;
      runEn  = 1'b1;
      scanReq = 1'b0;
      scanReq2 = 1'b0;
      outIf.outReady  = 1'b1;
      outIf2.outReady = 1'b1;

      // 1: reset values, then clkEnable follows runEn one cycle after release
      repeat (3) @(posedge clk);
      #1;
      check("reset clkEnable", 64'(clkEnable), 64'd0);
      check("reset busy/done/valid", {61'd0, busy, done, outIf.outValid}, 64'd0);
      check("reset regAddr", 64'(regAddr), 64'd1);
      check("reset outAddr/outData", {27'd0, outIf.outAddr, outIf.outData}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("clkEnable after release", 64'(clkEnable), 64'd1);
      check("idle busy/valid", {62'd0, busy, outIf.outValid}, 64'd0);

      // 2: full scan with outReady held high
      pushRange(1, 31);
      pairBase = pairsSeen;
      doneBase = doneCnt;
      @(posedge clk); #1;
      pulseScan();
      check("clkEnable drop", 64'(clkEnable), 64'd0);
      check("busy after scanReq", 64'(busy), 64'd1);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (outIf.outValid) begin
            lat = c;
            break;
         end
      end
      check("first valid latency", 64'(lat), 64'(HALT_CYC + SETTLE));
      check("first outAddr", 64'(outIf.outAddr), 64'd1);
      waitDone("scan2 done", 300);
      check("scan2 busy at done", 64'(busy), 64'd0);
      check("scan2 clkEnable restored", 64'(clkEnable), 64'd1);
      check("scan2 regAddr kept", 64'(regAddr), 64'd31);
      repeat (3) @(posedge clk); #1;
      check("scan2 pair count", 64'(pairsSeen - pairBase), 64'd31);
      check("scan2 done pulses", 64'(doneCnt - doneBase), 64'd1);
      check("scan2 queue drained", 64'(expQ.size()), 64'd0);

      // 3: backpressure on address 5
      pushRange(1, 31);
      pairBase = pairsSeen;
      pulseScan();
      waitRegAddr("reach addr 5", 5'd5);
      outIf.outReady = 1'b0;
      waitValid("addr 5 valid");
      for (int c = 0; c < 10; c++) begin
         check("backpressure hold", {21'd0, outIf.outValid, outIf.outAddr, outIf.outData, regAddr},
               {21'd0, 1'b1, 5'd5, rfVal(5'd5), 5'd5});
         @(posedge clk); #1;
      end
      check("no pair during stall", 64'(pairsSeen - pairBase), 64'd4);
      outIf.outReady = 1'b1;
      waitDone("scan3 done", 300);
      repeat (2) @(posedge clk); #1;
      check("scan3 pair count", 64'(pairsSeen - pairBase), 64'd31);
      check("scan3 queue drained", 64'(expQ.size()), 64'd0);

      // 4: scanReq and runEn activity mid-scan are ignored until FINISH
      pushRange(1, 31);
      pairBase = pairsSeen;
      doneBase = doneCnt;
      pulseScan();
      leak = 0;
      for (int c = 0; c < 300; c++) begin
         scanReq = (c == 5 || c == 50);
         if (c == 10) runEn = 1'b0;
         if (c == 20) runEn = 1'b1;
         if (c == 40) runEn = 1'b0;
         @(posedge clk); #1;
         if (done) break;
         if (clkEnable !== 1'b0) leak++;
      end
      scanReq = 1'b0;
      check("scan4 clkEnable held low", 64'(leak), 64'd0);
      check("scan4 done reached", 64'(done), 64'd1);
      check("scan4 clkEnable = runEn", 64'(clkEnable), 64'd0);
      runEn = 1'b1;
      @(posedge clk); #1;
      check("scan4 clkEnable follows runEn", 64'(clkEnable), 64'd1);
      busySeen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (busy) busySeen++;
      end
      check("scan4 no restart", 64'(busySeen), 64'd0);
      check("scan4 pair count", 64'(pairsSeen - pairBase), 64'd31);
      check("scan4 done pulses", 64'(doneCnt - doneBase), 64'd1);

      // 5: reset while stalled in EMIT at address 12
      pushRange(1, 11);
      pairBase = pairsSeen;
      doneBase = doneCnt;
      pulseScan();
      waitRegAddr("reach addr 12", 5'd12);
      outIf.outReady = 1'b0;
      waitValid("addr 12 valid");
      check("addr 12 presented", 64'(outIf.outAddr), 64'd12);
      rst = 1'b1;
      #1;
      check("midscan reset valid/busy/clkEn", {61'd0, outIf.outValid, busy, clkEnable}, 64'd0);
      check("midscan reset regAddr", 64'(regAddr), 64'd1);
      check("midscan reset outAddr/outData", {27'd0, outIf.outAddr, outIf.outData}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      outIf.outReady = 1'b1;
      check("midscan pairs before reset", 64'(pairsSeen - pairBase), 64'd11);
      check("midscan queue drained", 64'(expQ.size()), 64'd0);
      repeat (3) @(posedge clk); #1;
      check("no done after reset", 64'(doneCnt - doneBase), 64'd0);
      pushRange(1, 31);
      pairBase = pairsSeen;
      pulseScan();
      waitDone("restart done", 300);
      repeat (2) @(posedge clk); #1;
      check("restart pair count", 64'(pairsSeen - pairBase), 64'd31);
      check("restart queue drained", 64'(expQ.size()), 64'd0);

      // 6: single-register build emits one pair then done
      pairBase = pairs2;
      doneBase = doneCnt2;
      scanReq2 = 1'b1;
      @(posedge clk); #1;
      scanReq2 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (done2) break;
      end
      check("single done reached", 64'(done2), 64'd1);
      repeat (3) @(posedge clk); #1;
      check("single pair count", 64'(pairs2 - pairBase), 64'd1);
      check("single done pulses", 64'(doneCnt2 - doneBase), 64'd1);
      check("single regAddr kept", 64'(regAddr2), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: simulation did not complete, %0d failures so far", nFails);
      $fatal(1);
   end

endmodule
